mem_access_unit: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register: takes the registered load/store control and operands, performs a single-outstanding word access on a request/grant/response data-memory bus, and drives the MEM/WB pipeline register. It holds a pipeline stall while the access is in flight, so upstream stages freeze for variable-latency memory. It also handles misaligned addresses and bus timeouts.

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/grant/response data-memory bus between the MEM stage and data memory.
// One outstanding word access at a time; the master holds address/data until granted.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage: single-outstanding load/store on the data bus, pipeline stall while
// the access is in flight, MEM/WB register with misalign and bus-timeout flags.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              alu_MEM,
  input  logic [31:0]              writedata_MEM,
  input  logic [4:0]               rd_MEM,
  input  logic                     memread_MEM,
  input  logic                     memwrite_MEM,
  input  logic                     memtoreg_MEM,
  input  logic                     regwrite_MEM,
  output logic                     stall_MEM,
  mem_access_unit_if.master        bus,
  output logic [31:0]              readdata_WB,
  output logic [31:0]              alu_WB,
  output logic [4:0]               rd_WB,
  output logic                     memtoreg_WB,
  output logic                     regwrite_WB,
  output logic                     misalign_err_WB,
  output logic                     bus_err_WB
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;

  logic        mem_req_r, mem_we_r;
  logic [31:0] mem_addr_r, mem_wdata_r;
  logic [31:0] readdata_r, alu_wb_r;
  logic [4:0]  rd_wb_r;
  logic        memtoreg_wb_r, regwrite_wb_r, misalign_err_r, bus_err_r;

  logic access_s, aligned_s;
  logic stall_s, start_s, complete_s, load_done_s, misalign_s, timeout_s, cnt_inc_s;

  assign access_s  = memread_MEM | memwrite_MEM;
  assign aligned_s = (alu_MEM[1:0] == 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, stall and per-cycle event decode.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    start_s     = 1'b0;
    complete_s  = 1'b0;
    load_done_s = 1'b0;
    misalign_s  = 1'b0;
    timeout_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s) begin
          if (!aligned_s) begin
            misalign_s = 1'b1;
          end else begin
            start_s     = 1'b1;
            stall_s     = 1'b1;
            state_nxt_s = ST_REQ;
          end
        end else begin
          complete_s = 1'b1;
        end
      end
      ST_REQ: begin
        // A store finishing on its last allowed cycle beats the timeout.
        if (bus.mem_gnt && mem_we_r) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_MAX) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          stall_s   = 1'b1;
          cnt_inc_s = 1'b1;
          if (bus.mem_gnt) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
      end
      ST_RESP: begin
        if (bus.mem_rvalid) begin
          complete_s  = 1'b1;
          load_done_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_MAX) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          stall_s   = 1'b1;
          cnt_inc_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Timeout counter; never exceeds CNT_MAX because increments stop there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (start_s) begin
      cnt_r <= '0;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Bus request registers, held stable from launch until grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      mem_req_r <= (state_nxt_s == ST_REQ);
      if (start_s) begin
        mem_we_r    <= memwrite_MEM;
        mem_addr_r  <= alu_MEM;
        mem_wdata_r <= writedata_MEM;
      end
    end
  end

  // MEM/WB register: capture on completion, bubble on stall/misalign/abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readdata_r     <= 32'h0000_0000;
      alu_wb_r       <= 32'h0000_0000;
      rd_wb_r        <= 5'd0;
      memtoreg_wb_r  <= 1'b0;
      regwrite_wb_r  <= 1'b0;
      misalign_err_r <= 1'b0;
      bus_err_r      <= 1'b0;
    end else begin
      misalign_err_r <= misalign_s;
      bus_err_r      <= timeout_s;
      if (complete_s) begin
        alu_wb_r      <= alu_MEM;
        rd_wb_r       <= rd_MEM;
        memtoreg_wb_r <= memtoreg_MEM;
        regwrite_wb_r <= regwrite_MEM;
        if (load_done_s) begin
          readdata_r <= bus.mem_rdata;
        end
      end else begin
        rd_wb_r       <= 5'd0;
        memtoreg_wb_r <= 1'b0;
        regwrite_wb_r <= 1'b0;
      end
    end
  end

  assign stall_MEM       = stall_s;
  assign bus.mem_req     = mem_req_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wdata   = mem_wdata_r;
  assign readdata_WB     = readdata_r;
  assign alu_WB          = alu_wb_r;
  assign rd_WB           = rd_wb_r;
  assign memtoreg_WB     = memtoreg_wb_r;
  assign regwrite_WB     = regwrite_wb_r;
  assign misalign_err_WB = misalign_err_r;
  assign bus_err_WB      = bus_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops
// against a transaction-level model (stall count = min(bus cycles, timeout)).
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk, rst;
  logic [31:0] alu_MEM, writedata_MEM;
  logic [4:0]  rd_MEM;
  logic        memread_MEM, memwrite_MEM, memtoreg_MEM, regwrite_MEM;
  logic        stall_MEM;
  logic [31:0] readdata_WB, alu_WB;
  logic [4:0]  rd_WB;
  logic        memtoreg_WB, regwrite_WB, misalign_err_WB, bus_err_WB;

  mem_access_unit_if bus_if();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_MEM         (alu_MEM),
    .writedata_MEM   (writedata_MEM),
    .rd_MEM          (rd_MEM),
    .memread_MEM     (memread_MEM),
    .memwrite_MEM    (memwrite_MEM),
    .memtoreg_MEM    (memtoreg_MEM),
    .regwrite_MEM    (regwrite_MEM),
    .stall_MEM       (stall_MEM),
    .bus             (bus_if),
    .readdata_WB     (readdata_WB),
    .alu_WB          (alu_WB),
    .rd_WB           (rd_WB),
    .memtoreg_WB     (memtoreg_WB),
    .regwrite_WB     (regwrite_WB),
    .misalign_err_WB (misalign_err_WB),
    .bus_err_WB      (bus_err_WB)
  );

  int          total_cnt;
  int          bad_cnt;
  logic [31:0] exp_alu;
  logic [31:0] exp_rdata;
  logic        prev_abort;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Runs one EX/MEM instruction starting #1 after the edge that opens its IDLE cycle.
  // g = cycles the grant is withheld, r = cycles from grant to rvalid.
  task automatic run_op(input logic rd_op, input logic wr_op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic m2r,
                        input logic rw, input int g, input int r, input logic [31:0] rdata,
                        input logic late_rv, output logic aborted);
    logic acc, mis, is_load, granted, done, complete;
    int   n_bus, n_exp, stalls, req_cnt, since_gnt, cyc;

    acc     = rd_op | wr_op;
    mis     = acc && (addr[1:0] != 2'b00);
    is_load = rd_op && !wr_op;
    n_bus   = is_load ? (g + 1 + r) : (g + 1);
    if (!acc || mis) begin
      n_exp   = 0;
      aborted = 1'b0;
    end else begin
      n_exp   = (n_bus < TO) ? n_bus : TO;
      aborted = (n_bus > TO);
    end
    complete = !mis && !aborted;

    alu_MEM = addr; writedata_MEM = wdata; rd_MEM = rd;
    memread_MEM = rd_op; memwrite_MEM = wr_op; memtoreg_MEM = m2r; regwrite_MEM = rw;
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = late_rv | ($urandom_range(0, 3) == 0);
    bus_if.mem_rdata  = $urandom;

    stalls = 0; req_cnt = 0; since_gnt = 0; granted = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 64) begin
      if (cyc > 0) begin
        check_eq("bubble_regwrite", {31'd0, regwrite_WB}, 32'd0);
        check_eq("bubble_rd", {27'd0, rd_WB}, 32'd0);
        check_eq("bubble_err", {30'd0, misalign_err_WB, bus_err_WB}, 32'd0);
        if (!granted) begin
          check_eq("req_held", {31'd0, bus_if.mem_req}, 32'd1);
          check_eq("req_addr", bus_if.mem_addr, addr);
          check_eq("req_wdata", bus_if.mem_wdata, wdata);
          check_eq("req_we", {31'd0, bus_if.mem_we}, {31'd0, wr_op});
          bus_if.mem_gnt    = (req_cnt == g);
          bus_if.mem_rvalid = $urandom_range(0, 1);
          bus_if.mem_rdata  = $urandom;
          granted = bus_if.mem_gnt;
          req_cnt++;
        end else begin
          check_eq("resp_req_low", {31'd0, bus_if.mem_req}, 32'd0);
          since_gnt++;
          bus_if.mem_gnt    = 1'b0;
          bus_if.mem_rvalid = (since_gnt == r);
          bus_if.mem_rdata  = (since_gnt == r) ? rdata : $urandom;
        end
      end
      #3;
      if (stall_MEM) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("op_terminates", {31'd0, done}, 32'd1);
    check_eq("stall_cycles", 32'(stalls), 32'(n_exp));

    if (complete) exp_alu = addr;
    if (complete && is_load) exp_rdata = rdata;
    check_eq("wb_regwrite", {31'd0, regwrite_WB}, {31'd0, complete & rw});
    check_eq("wb_memtoreg", {31'd0, memtoreg_WB}, {31'd0, complete & m2r});
    check_eq("wb_rd", {27'd0, rd_WB}, complete ? {27'd0, rd} : 32'd0);
    check_eq("wb_alu", alu_WB, exp_alu);
    check_eq("wb_readdata", readdata_WB, exp_rdata);
    check_eq("misalign_flag", {31'd0, misalign_err_WB}, {31'd0, mis});
    check_eq("bus_err_flag", {31'd0, bus_err_WB}, {31'd0, aborted});
    check_eq("req_after_op", {31'd0, bus_if.mem_req}, 32'd0);
  endtask

  initial begin
    int          kind, g, r;
    logic        rd_op, wr_op, ab;
    logic [31:0] addr;

    clk = 1'b0; rst = 1'b0;
    alu_MEM = 32'd0; writedata_MEM = 32'd0; rd_MEM = 5'd0;
    memread_MEM = 1'b0; memwrite_MEM = 1'b0; memtoreg_MEM = 1'b0; regwrite_MEM = 1'b0;
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = 32'd0;
    total_cnt = 0; bad_cnt = 0; exp_alu = 32'd0; exp_rdata = 32'd0; prev_abort = 1'b0;

    #2;
    check_eq("rst_req", {31'd0, bus_if.mem_req}, 32'd0);
    check_eq("rst_we", {31'd0, bus_if.mem_we}, 32'd0);
    check_eq("rst_addr", bus_if.mem_addr, 32'd0);
    check_eq("rst_wdata", bus_if.mem_wdata, 32'd0);
    check_eq("rst_readdata", readdata_WB, 32'd0);
    check_eq("rst_alu", alu_WB, 32'd0);
    check_eq("rst_rd", {27'd0, rd_WB}, 32'd0);
    check_eq("rst_ctrl", {28'd0, memtoreg_WB, regwrite_WB, misalign_err_WB, bus_err_WB}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_MEM}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases: ALU op, zero-wait load, slow store, misaligned load, timeout.
    run_op(1'b0, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 1'b0, 1'b1, 0, 1, 32'd0, 1'b0, ab);
    run_op(1'b1, 1'b0, 32'h0000_0100, 32'd0, 5'd7, 1'b1, 1'b1, 0, 1, 32'hDEAD_BEEF, 1'b0, ab);
    run_op(1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 3, 1, 32'd0, 1'b0, ab);
    run_op(1'b1, 1'b0, 32'h0000_0102, 32'd0, 5'd3, 1'b1, 1'b1, 0, 1, 32'd0, 1'b0, ab);
    run_op(1'b1, 1'b0, 32'h0000_0300, 32'd0, 5'd4, 1'b1, 1'b1, 0, 20, 32'h1111_2222, 1'b0, ab);
    check_eq("timeout_expected", {31'd0, ab}, 32'd1);
    run_op(1'b0, 1'b0, 32'h0000_0ABC, 32'd0, 5'd9, 1'b0, 1'b1, 0, 1, 32'd0, 1'b1, ab);

    // Reset during RESP: request drops at once and a later rvalid is discarded.
    alu_MEM = 32'h0000_0400; memread_MEM = 1'b1; memwrite_MEM = 1'b0;
    rd_MEM = 5'd6; memtoreg_MEM = 1'b1; regwrite_MEM = 1'b1;
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
    @(posedge clk); #1;
    bus_if.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_gnt = 1'b0;
    #2; rst = 1'b0; #1;
    check_eq("mid_rst_req", {31'd0, bus_if.mem_req}, 32'd0);
    check_eq("mid_rst_idle_stall", {31'd0, stall_MEM}, 32'd1);
    alu_MEM = 32'h0000_0055; memread_MEM = 1'b0; rd_MEM = 5'd9;
    memtoreg_MEM = 1'b0; regwrite_MEM = 1'b1;
    bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = 32'h0BAD_0BAD;
    #1;
    check_eq("mid_rst_alu_stall", {31'd0, stall_MEM}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    bus_if.mem_rvalid = 1'b0;
    exp_alu = 32'h0000_0055; exp_rdata = 32'd0;
    check_eq("post_rst_readdata", readdata_WB, 32'd0);
    check_eq("post_rst_regwrite", {31'd0, regwrite_WB}, 32'd1);
    check_eq("post_rst_rd", {27'd0, rd_WB}, 32'd9);
    check_eq("post_rst_alu", alu_WB, 32'h0000_0055);

    // Randomized back-to-back instruction stream.
    for (int k = 0; k < 200; k++) begin
      kind = $urandom_range(0, 4);
      g    = $urandom_range(0, 4);
      r    = $urandom_range(1, 4);
      addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rd_op = (kind == 1) || (kind == 3) || (kind == 4);
      wr_op = (kind == 2) || (kind == 3);
      if (kind == 4) addr[1:0] = 2'($urandom_range(1, 3));
      run_op(rd_op, wr_op, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), g, r, $urandom, prev_abort, ab);
      prev_abort = ab;
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
